// File: rtl/dmem_arbiter.sv
// Shares the single-ported MWB data RAM between the pipeline (P) and debug (D) requesters:
// round-robin grant, IDLE/ISSUE/WAIT/RESP access sequencer, alignment and range checking.
module dmem_arbiter #(
  parameter int MEM_WORDS = 128,
  parameter int AW        = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [31:0]   p_addr,
  input  logic [31:0]   p_wdata,
  output logic [31:0]   p_rdata,
  output logic          p_ack,
  output logic          p_err,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // The range check uses the full 30-bit word index so large addresses never alias into the RAM.
  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t        state;
  owner_t        owner;
  owner_t        last_owner;
  logic          lat_we;
  logic [AW-1:0] lat_word;
  logic [31:0]   lat_wdata;
  logic          lat_err;

  logic          grant_d;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_err;
  logic          in_issue;
  logic          in_resp;

  // A lone request wins outright; on a tie the port not served last wins.
  assign grant_d   = d_req & (~p_req | (last_owner == OWN_P));
  assign sel_we    = grant_d ? d_we    : p_we;
  assign sel_addr  = grant_d ? d_addr  : p_addr;
  assign sel_wdata = grant_d ? d_wdata : p_wdata;
  assign sel_err   = (sel_addr[1:0] != 2'b00) | (sel_addr[31:2] >= WORD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_P;
      last_owner <= OWN_D;
      lat_we     <= 1'b0;
      lat_word   <= '0;
      lat_wdata  <= '0;
      lat_err    <= 1'b0;
      p_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p_req | d_req) begin
            owner      <= grant_d ? OWN_D : OWN_P;
            last_owner <= grant_d ? OWN_D : OWN_P;
            lat_we     <= sel_we;
            lat_word   <= sel_addr[AW+1:2];
            lat_wdata  <= sel_wdata;
            lat_err    <= sel_err;
            if (sel_err) begin
              // Bad accesses skip the RAM entirely and answer with zero data.
              state <= RESP;
              if (grant_d) begin
                d_rdata <= '0;
              end else begin
                p_rdata <= '0;
              end
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (owner == OWN_D) begin
            d_rdata <= lat_we ? 32'h0 : mem_rdata;
          end else begin
            p_rdata <= lat_we ? 32'h0 : mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so they drop the instant reset asserts.
  assign in_issue  = (state == ISSUE);
  assign in_resp   = (state == RESP);

  assign mem_en    = in_issue;
  assign mem_we    = in_issue & lat_we;
  assign mem_addr  = in_issue ? lat_word  : '0;
  assign mem_wdata = in_issue ? lat_wdata : 32'h0;

  assign p_ack     = in_resp & (owner == OWN_P);
  assign d_ack     = in_resp & (owner == OWN_D);
  assign p_err     = p_ack & lat_err;
  assign d_err     = d_ack & lat_err;
  assign p_stall   = p_req & ~p_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, hand sequences for tie/reset corners, and random
// traffic scored against a word-array memory model with round-robin and latency rules.
module tb_dmem_arbiter;

  localparam int MEM_WORDS = 128;
  localparam int AW        = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p_req, p_we, d_req, d_we;
  logic [31:0]   p_addr, p_wdata, d_addr, d_wdata;
  logic [31:0]   p_rdata, d_rdata;
  logic          p_ack, p_err, p_stall, d_ack, d_err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;
  int last_served;  // 0 = P, 1 = D

  logic [31:0] ram    [MEM_WORDS];
  logic [31:0] shadow [MEM_WORDS];

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic        e;
  } obs_t;

  typedef struct {
    int          cnt;
    int          first;
    logic [AW-1:0] addr;
    logic        we;
    logic [31:0] wd;
  } mon_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t vt [11];

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ack(p_ack), .p_err(p_err), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_WORDS));
  endfunction

  // Reference: an access either errors (no memory effect, one-cycle response) or acts on the word array.
  task automatic model_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit e, output int lat);
    e   = addr_bad(a);
    rd  = 32'h0;
    lat = e ? 1 : 3;
    if (!e) begin
      if (we) shadow[a[AW+1:2]] = wd;
      else    rd = shadow[a[AW+1:2]];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      a[1:0] = 2'($urandom_range(1, 3));
    end else if (r == 1) begin
      a = $urandom();
      a[9] = 1'b1;
      a[1:0] = 2'b00;
    end else begin
      a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
    end
    return a;
  endfunction

  // Raises the enabled requests in an IDLE cycle, follows them to completion and returns to IDLE.
  task automatic run_op(input bit en_p, input bit pwe, input logic [31:0] paddr, input logic [31:0] pwd,
                        input bit en_d, input bit dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                        output obs_t po, output obs_t dobs, output mon_t mon);
    bit p_done, d_done;
    int n;
    po   = '{-1, 32'h0, 1'b0};
    dobs = '{-1, 32'h0, 1'b0};
    mon  = '{0, -1, '0, 1'b0, 32'h0};
    p_we = pwe; p_addr = paddr; p_wdata = pwd; p_req = en_p;
    d_we = dwe; d_addr = daddr; d_wdata = dwd; d_req = en_d;
    p_done = !en_p;
    d_done = !en_d;
    n = 0;
    while (!(p_done && d_done) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (mem_en) begin
        if (mon.cnt == 0) mon.first = n;
        mon.cnt++;
        mon.addr = mem_addr; mon.we = mem_we; mon.wd = mem_wdata;
      end else begin
        chk("mem_idle_zero", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
      end
      chk("p_stall", 64'(p_stall), 64'(p_req & ~p_ack));
      chk("single_ack", 64'(p_ack & d_ack), 64'(0));
      chk("p_unexpected_ack", 64'(p_ack & p_done), 64'(0));
      chk("d_unexpected_ack", 64'(d_ack & d_done), 64'(0));
      if (p_ack && !p_done) begin
        p_done = 1'b1; po.lat = n; po.rd = p_rdata; po.e = p_err; p_req = 1'b0;
      end
      if (d_ack && !d_done) begin
        d_done = 1'b1; dobs.lat = n; dobs.rd = d_rdata; dobs.e = d_err; d_req = 1'b0;
      end
    end
    chk("op_completed", 64'({p_done, d_done}), 64'(2'b11));
    @(posedge clk); #1;
    chk("ack_one_cycle", 64'({p_ack, d_ack}), 64'(0));
    txn_id++;
    $display("txn %0d: p(req=%0b we=%0b addr=%h) d(req=%0b we=%0b addr=%h) -> p_lat=%0d p_rd=%h p_err=%0b d_lat=%0d d_rd=%h d_err=%0b",
             txn_id, en_p, pwe, paddr, en_d, dwe, daddr, po.lat, po.rd, po.e, dobs.lat, dobs.rd, dobs.e);
  endtask

  task automatic chk_obs(input string tag, input obs_t o, input int lat, input logic [31:0] rd, input bit e);
    chk({tag, "_lat"},   64'(o.lat), 64'(lat));
    chk({tag, "_rdata"}, 64'(o.rd),  64'(rd));
    chk({tag, "_err"},   64'(o.e),   64'(e));
  endtask

  initial begin
    obs_t po, dobs;
    mon_t mon;
    logic [31:0] erd, erd2;
    bit ee, ee2;
    int el, el2;

    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i]    = 32'h100 * i + 32'd12;
      shadow[i] = 32'h100 * i + 32'd12;
    end
    last_served = 1;

    vt[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'd12,        3, 1};
    vt[1]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h55,        1'b0, 32'h0,         3, 1};
    vt[2]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h55,        3, 1};
    vt[3]  = '{1'b0, 1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 1'b1, 32'h0,         1, 0};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'h0,         1, 0};
    vt[5]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h10C,       3, 1};
    vt[6]  = '{1'b1, 1'b1, 32'h0000_01FC, 32'hA5A5_A5A5, 1'b0, 32'h0,         3, 1};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'hA5A5_A5A5, 3, 1};
    vt[8]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,         1, 0};
    vt[9]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h11,        1'b1, 32'h0,         1, 0};
    vt[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'd12,        3, 1};

    // Reset state, including the combinational stall path.
    rst_n = 1'b0;
    p_req = 1'b1; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1;
    chk("rst_acks",  64'({p_ack, d_ack, p_err, d_err}), 64'(0));
    chk("rst_mem",   64'({mem_en, mem_we, mem_addr}), 64'(0));
    chk("rst_rdata", {p_rdata, d_rdata}, 64'(0));
    chk("rst_stall_req", 64'(p_stall), 64'(1));
    p_req = 1'b0;
    #1;
    chk("rst_stall_idle", 64'(p_stall), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      if (vt[i].port)
        run_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata, po, dobs, mon);
      else
        run_op(1'b1, vt[i].we, vt[i].addr, vt[i].wdata, 1'b0, 1'b0, 32'h0, 32'h0, po, dobs, mon);
      chk_obs("vec", vt[i].port ? dobs : po, vt[i].exp_lat, vt[i].exp_rd, vt[i].exp_err);
      chk("vec_mem_en_count", 64'(mon.cnt), 64'(vt[i].exp_en));
      if (vt[i].exp_en != 0) begin
        chk("vec_mem_en_cycle", 64'(mon.first), 64'(1));
        chk("vec_mem_addr", 64'(mon.addr), 64'(vt[i].addr[AW+1:2]));
        chk("vec_mem_we", 64'(mon.we), 64'(vt[i].we));
        if (vt[i].we) chk("vec_mem_wdata", 64'(mon.wd), 64'(vt[i].wdata));
      end
      model_op(vt[i].we, vt[i].addr, vt[i].wdata, erd, ee, el);
      last_served = vt[i].port ? 1 : 0;
    end

    // Both ports hold requests for three loads each; last grant was D, so P leads.
    begin
      int order [8];
      int k, pc, dc, n;
      logic prev_p, prev_d;
      k = 0; pc = 0; dc = 0; n = 0; prev_p = 1'b0; prev_d = 1'b0;
      p_we = 1'b0; d_we = 1'b0;
      p_addr = 32'd40; d_addr = 32'd80;
      p_req = 1'b1; d_req = 1'b1;
      while ((pc < 3 || dc < 3) && n < 80) begin
        @(posedge clk); #1;
        n++;
        chk("rr_single_ack", 64'(p_ack & d_ack), 64'(0));
        chk("rr_p_ack_width", 64'(p_ack & prev_p), 64'(0));
        chk("rr_d_ack_width", 64'(d_ack & prev_d), 64'(0));
        prev_p = p_ack; prev_d = d_ack;
        if (p_ack && k < 8) begin
          order[k] = 0; k++;
          chk("rr_p_rdata", 64'(p_rdata), 64'(shadow[10 + pc]));
          $display("txn rr: P load word %0d rdata=%h at cycle %0d", 10 + pc, p_rdata, n);
          pc++;
          if (pc < 3) p_addr = 32'(4 * (10 + pc));
          else        p_req = 1'b0;
        end
        if (d_ack && k < 8) begin
          order[k] = 1; k++;
          chk("rr_d_rdata", 64'(d_rdata), 64'(shadow[20 + dc]));
          $display("txn rr: D load word %0d rdata=%h at cycle %0d", 20 + dc, d_rdata, n);
          dc++;
          if (dc < 3) d_addr = 32'(4 * (20 + dc));
          else        d_req = 1'b0;
        end
      end
      chk("rr_count", 64'(k), 64'(6));
      for (int j = 0; j < 6; j++) chk("rr_order", 64'(order[j]), 64'(j % 2));
      @(posedge clk); #1;
      last_served = 1;
    end

    // Reset in the WAIT state of a P load drops the access; a held request then completes.
    begin
      int n, lat;
      bit got;
      logic [31:0] rd;
      run_op(1'b1, 1'b1, 32'd20, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 32'h0, po, dobs, mon);
      model_op(1'b1, 32'd20, 32'hCAFE_0001, erd, ee, el);
      chk_obs("pre_rst_store", po, el, erd, ee);
      run_op(1'b1, 1'b0, 32'd20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, po, dobs, mon);
      model_op(1'b0, 32'd20, 32'h0, erd, ee, el);
      chk_obs("pre_rst_load", po, el, erd, ee);
      p_we = 1'b0; p_addr = 32'd20; p_req = 1'b1;
      @(posedge clk); #1;
      chk("rst_issue_en", 64'(mem_en), 64'(1));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_en", 64'(mem_en), 64'(0));
      chk("midrst_p_rdata", 64'(p_rdata), 64'(0));
      chk("midrst_p_ack", 64'(p_ack), 64'(0));
      chk("midrst_p_stall", 64'(p_stall), 64'(1));
      repeat (2) begin
        @(posedge clk); #1;
        chk("midrst_hold_ack", 64'({p_ack, mem_en}), 64'(0));
      end
      rst_n = 1'b1;
      n = 0; got = 1'b0; lat = -1; rd = 32'h0;
      while (!got && n < 20) begin
        @(posedge clk); #1;
        n++;
        if (p_ack) begin
          got = 1'b1; lat = n; rd = p_rdata; p_req = 1'b0;
        end
      end
      chk("rst_recover_lat", 64'(lat), 64'(3));
      chk("rst_recover_rdata", 64'(rd), 64'(32'hCAFE_0001));
      $display("txn rst: P load after reset lat=%0d rdata=%h", lat, rd);
      @(posedge clk); #1;
      last_served = 0;
    end

    // Random traffic, singles and simultaneous pairs.
    for (int i = 0; i < 250; i++) begin
      bit pair, use_d, pwe_r, dwe_r;
      logic [31:0] pa, pw, da, dw;
      pair  = ($urandom_range(0, 3) == 0);
      use_d = 1'($urandom_range(0, 1));
      pwe_r = 1'($urandom_range(0, 1));
      dwe_r = 1'($urandom_range(0, 1));
      pa = rand_addr(); pw = $urandom();
      da = rand_addr(); dw = $urandom();
      if (pair) begin
        if (last_served == 0) begin
          model_op(dwe_r, da, dw, erd2, ee2, el2);
          model_op(pwe_r, pa, pw, erd, ee, el);
          el = el2 + 1 + el;
          last_served = 0;
        end else begin
          model_op(pwe_r, pa, pw, erd, ee, el);
          model_op(dwe_r, da, dw, erd2, ee2, el2);
          el2 = el + 1 + el2;
          last_served = 1;
        end
        run_op(1'b1, pwe_r, pa, pw, 1'b1, dwe_r, da, dw, po, dobs, mon);
        chk_obs("rnd_pair_p", po, el, erd, ee);
        chk_obs("rnd_pair_d", dobs, el2, erd2, ee2);
        chk("rnd_pair_mem_en", 64'(mon.cnt), 64'(int'(!ee) + int'(!ee2)));
      end else begin
        if (use_d) begin
          model_op(dwe_r, da, dw, erd, ee, el);
          run_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, dwe_r, da, dw, po, dobs, mon);
          chk_obs("rnd_d", dobs, el, erd, ee);
          last_served = 1;
        end else begin
          model_op(pwe_r, pa, pw, erd, ee, el);
          run_op(1'b1, pwe_r, pa, pw, 1'b0, 1'b0, 32'h0, 32'h0, po, dobs, mon);
          chk_obs("rnd_p", po, el, erd, ee);
          last_served = 0;
        end
        chk("rnd_mem_en", 64'(mon.cnt), 64'(int'(!ee)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported data memory of the MWB stage between two requesters: the pipeline load/store port (P) and a debug/program-loader port (D).
- Requesters use a req/ack handshake.
- Drives a synchronous RAM with 1-cycle read latency.
- Generates the pipeline stall while a P access is outstanding, and flags misaligned or out-of-range accesses.

Parameters:
- MEM_WORDS, 128, number of 32-bit words in the data memory
- AW, 7, word-address width; must equal clog2(MEM_WORDS)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- p_req  input  1  pipeline access request; held until p_ack
- p_we  input  1  1 = store, 0 = load
- p_addr  input  32  byte address
- p_wdata  input  32  store data
- p_rdata  output  32  load data, valid while p_ack=1
- p_ack  output  1  one-cycle completion pulse
- p_err  output  1  error flag, valid with p_ack
- p_stall  output  1  p_req & ~p_ack (combinational)
- d_req, d_we, d_addr, d_wdata  inputs  1/1/32/32  debug port, same rules as P
- d_rdata  output  32  debug read data, valid with d_ack
- d_ack  output  1  one-cycle completion pulse
- d_err  output  1  error flag, valid with d_ack
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable
- mem_addr  output  AW  RAM word address
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Requesters hold req, we, addr and wdata stable from req rise until ack.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present: latch owner, we, word address (addr>>2), wdata and error status, then:
  - error (addr[1:0]!=0, or addr>>2 >= MEM_WORDS): go to RESP.
  - otherwise: go to ISSUE.
- Arbitration (IDLE only):
  - Only one req high: that port wins.
  - Both high: round-robin via last_owner register; the port not served last wins. last_owner updates on every grant.
  - last_owner resets to D, so P wins the first tie.
- ISSUE:
  - mem_en=1, mem_we=latched we, mem_addr=latched word address [AW-1:0], mem_wdata=latched wdata.
  - Next state WAIT.
  - In every other state mem_en=0, mem_we=0, and mem_addr/mem_wdata are 0.
- WAIT:
  - Owner's rdata register loads mem_rdata for a load, 0 for a store.
  - Next state RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle; owner's err=1 if the latched error is set, with rdata forced to 0.
  - Next state IDLE.
  - Non-owner ack/err stay 0; non-owner rdata holds its last value.
- Latency:
  - Valid access: req sampled in IDLE cycle t; mem_en in t+1; ack in t+3; earliest next grant in t+4.
  - Error access: ack in t+1 and the RAM is never touched; a store to an invalid address must not write.
- A req still high in the IDLE cycle after ack is a new request. Requesters must drop req the cycle after ack.
- A request arriving while the FSM is busy waits. p_stall stays high throughout and there is no timeout.
- Reset (asynchronous, any state, including mid-access):
  - FSM to IDLE.
  - ack, err, mem_en and mem_we to 0.
  - rdata registers and latched fields to 0.
  - last_owner to D.
  - An interrupted access is dropped without an ack; the requester must re-request.
- At reset p_stall = p_req (combinational).

Test Plan:
- Reset then P load of word 0 with RAM word 0 = 12, p_addr=0 → mem_en at t+1 with mem_addr=0, p_ack at t+3 with p_rdata=12, p_stall high t..t+2.
- D store 0x55 to byte address 32, then P load from 32 → mem_we=1 with mem_addr=8 and mem_wdata=0x55; P load returns 0x55; d_rdata=0 for the store.
- P and D both request in the same cycle, held through 3 back-to-back transactions each → grant order P, D, P, D, P, D; every ack lasts one cycle and at most one ack is high per cycle.
- P store to p_addr=0x6 (misaligned), then D load from d_addr=512 (out of range) → each acks in t+1 with err=1 and rdata=0, mem_en never asserted, RAM contents unchanged.
- rst_n pulled low in the WAIT state of a P load → no p_ack; mem_en=0 and p_rdata=0 immediately. After release with p_req still high, the access completes normally 3 cycles later.
